wb_arbiter_2m: RTL and testbench

Two-master, one-slave Wishbone arbiter that shares the single external Wishbone bus between the CPU's data-side and instruction-side bus interface units. It sits between the two `wishbone_bus_if` instances and the SoC interconnect. It grants ownership per bus cycle (`cyc`), arbitrates round-robin on contention, routes `ack`/`err`/read data back only to the owner, and aborts slave cycles that exceed a timeout.

---
 rtl/wb_arbiter_2m_pkg.sv | 17 +
 rtl/wb_arb_timeout.sv | 27 ++
 rtl/wb_arbiter_2m.sv | 146 ++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_2m_pkg.sv
// rtl/wb_arbiter_2m_pkg.sv - shared encodings and constants for the two-master Wishbone arbiter
package wb_arbiter_2m_pkg;

    typedef enum logic [1:0] {
        WB_ARB_IDLE  = 2'd0,
        WB_ARB_OWN0  = 2'd1,
        WB_ARB_OWN1  = 2'd2,
        WB_ARB_DRAIN = 2'd3
    } wb_arb_state_e;

    localparam int unsigned WB_ARB_TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam logic LAST_M0 = 1'b0;
    localparam logic LAST_M1 = 1'b1;

endpackage

// File: rtl/wb_arb_timeout.sv
// rtl/wb_arb_timeout.sv - 8-bit stall counter that flags when a slave access has run too long
module wb_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [7:0] LP_LIMIT = TIMEOUT_CYCLES[7:0];

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    // A limit of zero disables the abort; the counter may wrap harmlessly.
    assign o_expire = (LP_LIMIT != 8'd0) && (r_count == LP_LIMIT);

endmodule

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - round-robin two-master, one-slave Wishbone arbiter with stall timeout
module wb_arbiter_2m
    import wb_arbiter_2m_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WB_ARB_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    output logic [1:0]  grant_o
);

    wb_arb_state_e r_state;
    wb_arb_state_e w_next;
    logic          r_last;
    logic          w_stb_own;
    logic          w_expire;
    logic          w_timeout;
    logic          w_clear;

    assign w_stb_own = ((r_state == WB_ARB_OWN0) && m0_stb_i) ||
                       ((r_state == WB_ARB_OWN1) && m1_stb_i);
    // A response arriving on the final stall cycle wins over the abort.
    assign w_timeout = w_expire && w_stb_own && !s_ack_i && !s_err_i;
    assign w_clear   = (w_next != r_state) || !w_stb_own || s_ack_i || s_err_i;

    wb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (w_stb_own),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WB_ARB_IDLE;
            r_last  <= LAST_M1;
        end else begin
            r_state <= w_next;
            if (w_next == WB_ARB_OWN0) begin
                r_last <= LAST_M0;
            end else if (w_next == WB_ARB_OWN1) begin
                r_last <= LAST_M1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = 4'h0;
        s_addr_o  = ZeroWord;
        s_data_o  = ZeroWord;
        m0_data_o = ZeroWord;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_data_o = ZeroWord;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        grant_o   = 2'b00;
        case (r_state)
            WB_ARB_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_next = (r_last == LAST_M1) ? WB_ARB_OWN0 : WB_ARB_OWN1;
                end else if (m0_cyc_i) begin
                    w_next = WB_ARB_OWN0;
                end else if (m1_cyc_i) begin
                    w_next = WB_ARB_OWN1;
                end
            end
            WB_ARB_OWN0: begin
                grant_o   = 2'b01;
                s_cyc_o   = m0_cyc_i && !w_timeout;
                s_stb_o   = m0_stb_i && !w_timeout;
                s_we_o    = m0_we_i;
                s_sel_o   = m0_sel_i;
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                m0_data_o = s_data_i;
                m0_ack_o  = s_ack_i;
                m0_err_o  = s_err_i || w_timeout;
                if (w_timeout) begin
                    w_next = WB_ARB_DRAIN;
                end else if (!m0_cyc_i) begin
                    w_next = m1_cyc_i ? WB_ARB_OWN1 : WB_ARB_IDLE;
                end
            end
            WB_ARB_OWN1: begin
                grant_o   = 2'b10;
                s_cyc_o   = m1_cyc_i && !w_timeout;
                s_stb_o   = m1_stb_i && !w_timeout;
                s_we_o    = m1_we_i;
                s_sel_o   = m1_sel_i;
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                m1_data_o = s_data_i;
                m1_ack_o  = s_ack_i;
                m1_err_o  = s_err_i || w_timeout;
                if (w_timeout) begin
                    w_next = WB_ARB_DRAIN;
                end else if (!m1_cyc_i) begin
                    w_next = m0_cyc_i ? WB_ARB_OWN0 : WB_ARB_IDLE;
                end
            end
            WB_ARB_DRAIN: begin
                // r_last still names the aborted master; wait for it to let go.
                if ((r_last == LAST_M1) ? !m1_cyc_i : !m0_cyc_i) begin
                    w_next = WB_ARB_IDLE;
                end
            end
            default: w_next = WB_ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - directed vector bench for the two-master Wishbone arbiter
module tb_wb_arbiter_2m;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;
    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'h2222_2222;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m1_cyc, m1_stb;
    logic [31:0] s_din;
    logic        s_ack, s_err;

    logic [31:0] a_m0_data, a_m1_data, a_s_addr, a_s_data;
    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
    logic        a_s_cyc, a_s_stb, a_s_we;
    logic [3:0]  a_s_sel;
    logic [1:0]  a_grant;

    logic [31:0] b_m0_data, b_m1_data, b_s_addr, b_s_data;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
    logic        b_s_cyc, b_s_stb, b_s_we;
    logic [3:0]  b_s_sel;
    logic [1:0]  b_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.TIMEOUT_CYCLES(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(1'b1), .m0_sel_i(4'hF),
        .m0_addr_i(A0), .m0_data_i(D0),
        .m0_data_o(a_m0_data), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(1'b0), .m1_sel_i(4'h3),
        .m1_addr_i(A1), .m1_data_i(D1),
        .m1_data_o(a_m1_data), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
        .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_sel_o(a_s_sel),
        .s_addr_o(a_s_addr), .s_data_o(a_s_data),
        .s_data_i(s_din), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(a_grant)
    );

    wb_arbiter_2m #(.TIMEOUT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(1'b1), .m0_sel_i(4'hF),
        .m0_addr_i(A0), .m0_data_i(D0),
        .m0_data_o(b_m0_data), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(1'b0), .m1_sel_i(4'h3),
        .m1_addr_i(A1), .m1_data_i(D1),
        .m1_data_o(b_m1_data), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_sel_o(b_s_sel),
        .s_addr_o(b_s_addr), .s_data_o(b_s_data),
        .s_data_i(s_din), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(b_grant)
    );

    typedef struct packed {
        logic        rst;
        logic        c0, s0, c1, s1, ack, err;
        logic [31:0] sdat;
        logic [1:0]  grant;
        logic        scyc, sstb;
        logic [31:0] saddr;
        logic        a0, e0;
        logic [31:0] d0;
        logic        a1, e1;
        logic [31:0] d1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic c0, input logic s0, input logic c1, input logic s1,
                       input logic ack, input logic err, input logic [31:0] sdat,
                       input logic [1:0] g, input logic scyc, input logic sstb, input logic [31:0] saddr,
                       input logic a0, input logic e0, input logic [31:0] d0,
                       input logic a1, input logic e1, input logic [31:0] d1);
        tbl.push_back('{r, c0, s0, c1, s1, ack, err, sdat, g, scyc, sstb, saddr, a0, e0, d0, a1, e1, d1});
    endtask

    function automatic logic [140:0] expect_of(input vec_t v);
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wd;
        we = 1'b0; sel = 4'h0; wd = 32'h0;
        if (v.saddr == A0) begin we = 1'b1; sel = 4'hF; wd = D0; end
        else if (v.saddr == A1) begin we = 1'b0; sel = 4'h3; wd = D1; end
        return {v.grant, v.scyc, v.sstb, we, sel, v.saddr, wd, v.a0, v.e0, v.d0, v.a1, v.e1, v.d1};
    endfunction

    function automatic logic [140:0] actual_a();
        return {a_grant, a_s_cyc, a_s_stb, a_s_we, a_s_sel, a_s_addr, a_s_data,
                a_m0_ack, a_m0_err, a_m0_data, a_m1_ack, a_m1_err, a_m1_data};
    endfunction

    initial begin
        int a_err_cnt;
        int a_err_at;
        logic b_stall_ok;
        logic [140:0] exp_v;
        logic [140:0] act_v;

        // rst c0 s0 c1 s1 ack err sdat  | grant cyc stb addr | a0 e0 d0 | a1 e1 d1
        add(1,0,0,0,0,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        add(0,0,0,0,0,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        // m0 alone, ack on its 3rd slave cycle
        add(0,1,1,0,0,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        add(0,1,1,0,0,0,0,0,            1,1,1,A0, 0,0,0, 0,0,0);
        add(0,1,1,0,0,0,0,0,            1,1,1,A0, 0,0,0, 0,0,0);
        add(0,1,1,0,0,1,0,32'hDEADBEEF, 1,1,1,A0, 1,0,32'hDEADBEEF, 0,0,0);
        add(0,0,0,0,0,0,0,0,            1,0,0,A0, 0,0,0, 0,0,0);
        add(0,0,0,0,0,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        // tie after reset goes to m0, then alternation on handoff
        add(1,0,0,0,0,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        add(0,1,1,1,1,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        add(0,1,1,1,1,1,0,32'hA5A5A5A5, 1,1,1,A0, 1,0,32'hA5A5A5A5, 0,0,0);
        add(0,0,0,1,1,0,0,0,            1,0,0,A0, 0,0,0, 0,0,0);
        add(0,1,1,1,1,1,0,32'h5A5A5A5A, 2,1,1,A1, 0,0,0, 1,0,32'h5A5A5A5A);
        add(0,1,1,0,0,0,0,0,            2,0,0,A1, 0,0,0, 0,0,0);
        add(0,0,0,1,1,0,0,0,            1,0,0,A0, 0,0,0, 0,0,0);
        add(0,1,1,0,0,0,0,0,            2,0,0,A1, 0,0,0, 0,0,0);
        add(0,0,0,0,0,0,0,0,            1,0,0,A0, 0,0,0, 0,0,0);
        add(0,0,0,0,0,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        // m1 burst of 3 beats while m0 waits
        add(0,1,1,1,1,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        add(0,1,1,1,1,1,0,32'd1,        2,1,1,A1, 0,0,0, 1,0,32'd1);
        add(0,1,1,1,1,1,0,32'd2,        2,1,1,A1, 0,0,0, 1,0,32'd2);
        add(0,1,1,1,1,1,0,32'd3,        2,1,1,A1, 0,0,0, 1,0,32'd3);
        add(0,1,1,0,0,0,0,0,            2,0,0,A1, 0,0,0, 0,0,0);
        add(0,1,1,0,0,0,0,0,            1,1,1,A0, 0,0,0, 0,0,0);
        add(0,0,0,0,0,0,0,0,            1,0,0,A0, 0,0,0, 0,0,0);
        add(0,0,0,0,0,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        // timeout of 4, drain, then m1 served
        add(0,1,1,0,0,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        add(0,1,1,0,0,0,0,0,            1,1,1,A0, 0,0,0, 0,0,0);
        add(0,1,1,0,0,0,0,0,            1,1,1,A0, 0,0,0, 0,0,0);
        add(0,1,1,1,1,0,0,0,            1,1,1,A0, 0,0,0, 0,0,0);
        add(0,1,1,1,1,0,0,0,            1,1,1,A0, 0,0,0, 0,0,0);
        add(0,1,1,1,1,0,0,0,            1,0,0,A0, 0,1,0, 0,0,0);
        add(0,1,1,1,1,1,0,32'hBAADF00D, 0,0,0,0,  0,0,0, 0,0,0);
        add(0,1,1,1,1,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        add(0,0,0,1,1,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        add(0,0,0,1,1,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        add(0,0,0,1,1,1,0,32'hCAFEF00D, 2,1,1,A1, 0,0,0, 1,0,32'hCAFEF00D);
        add(0,0,0,0,0,0,0,0,            2,0,0,A1, 0,0,0, 0,0,0);
        add(0,0,0,0,0,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        // reset while m1 owns with stb high, then m1 served; ack+err forwarded together
        add(0,0,0,1,1,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        add(0,0,0,1,1,0,0,0,            2,1,1,A1, 0,0,0, 0,0,0);
        add(1,0,0,1,1,0,0,0,            2,1,1,A1, 0,0,0, 0,0,0);
        add(0,0,0,1,1,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);
        add(0,0,0,1,1,1,1,32'h12345678, 2,1,1,A1, 0,0,0, 1,1,32'h12345678);
        add(0,0,0,0,0,0,0,0,            2,0,0,A1, 0,0,0, 0,0,0);
        add(0,0,0,0,0,0,0,0,            0,0,0,0,  0,0,0, 0,0,0);

        rst = 1'b1; m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_ack = 1'b0; s_err = 1'b0; s_din = 32'h0;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0;
            m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1;
            s_ack = tbl[i].ack; s_err = tbl[i].err; s_din = tbl[i].sdat;
            @(negedge clk);
            exp_v = expect_of(tbl[i]);
            act_v = actual_a();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL vec%0d got=%h exp=%h", i, act_v, exp_v);
            end
            @(posedge clk); #1;
        end

        // Long stall: disabled timeout must wait; timeout of 4 aborts once.
        rst = 1'b1; m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_ack = 1'b0; s_err = 1'b0; s_din = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
        a_err_cnt = 0; a_err_at = -1; b_stall_ok = 1'b1;
        for (int c = 0; c <= 1002; c++) begin
            if (c == 1000) begin s_ack = 1'b1; s_din = 32'hFEEDFACE; end
            if (c == 1001) begin s_ack = 1'b0; s_din = 32'h0; m0_cyc = 1'b0; m0_stb = 1'b0; end
            @(negedge clk);
            if (c >= 1 && c <= 999 && (b_m0_err !== 1'b0 || b_s_stb !== 1'b1 || b_m0_ack !== 1'b0))
                b_stall_ok = 1'b0;
            if (a_m0_err === 1'b1) begin a_err_cnt++; a_err_at = c; end
            if (c == 1000) begin
                checks++;
                if ({b_m0_ack, b_m0_err, b_m0_data} !== {1'b1, 1'b0, 32'hFEEDFACE}) begin
                    errors++;
                    $display("FAIL long_ack got=%b%b_%h exp=10_feedface", b_m0_ack, b_m0_err, b_m0_data);
                end
            end
            if (c == 1002) begin
                checks++;
                if ({b_grant, b_s_cyc} !== 3'b000) begin
                    errors++;
                    $display("FAIL long_idle got=%b%b exp=000", b_grant, b_s_cyc);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (b_stall_ok !== 1'b1) begin
            errors++;
            $display("FAIL long_stall got=%b exp=1", b_stall_ok);
        end
        checks++;
        if (a_err_cnt != 1 || a_err_at != 5) begin
            errors++;
            $display("FAIL to4_pulse got=%0d@%0d exp=1@5", a_err_cnt, a_err_at);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
